// File: rtl/cpu_mulx_pkg.sv
// Shared types and constants for the sequential MUL/MULX unit: op and state encodings,
// partial-product weight tags and the helper that aligns a tagged product into the accumulator.
package cpu_mulx_pkg;

    localparam int unsigned PP_W  = 16;
    localparam int unsigned ACC_W = 64;

    typedef enum logic [1:0] {
        OpMul    = 2'd0,
        OpMulxUu = 2'd1,
        OpMulxSu = 2'd2,
        OpMulxSs = 2'd3
    } mulx_op_e;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StDrain,
        StFix,
        StDone
    } mulx_state_e;

    typedef enum logic [1:0] {
        Wgt0,
        Wgt16,
        Wgt32
    } pp_wgt_e;

    function automatic logic [ACC_W-1:0] pp_align(input logic [2*PP_W-1:0] p,
                                                  input pp_wgt_e           w);
        logic [ACC_W-1:0] ext;
        ext = {{(ACC_W - 2*PP_W){1'b0}}, p};
        case (w)
            Wgt16:   pp_align = ext << PP_W;
            Wgt32:   pp_align = ext << (2*PP_W);
            default: pp_align = ext;
        endcase
    endfunction

endpackage

// File: rtl/cpu_mulx_pp16.sv
// Registered 16x16 unsigned multiplier with MULT_LATENCY output stages; intended to map onto
// a dedicated DSP multiplier block.
module cpu_mulx_pp16
    import cpu_mulx_pkg::*;
#(
    parameter int unsigned MULT_LATENCY = 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [PP_W-1:0]     i_a,
    input  logic [PP_W-1:0]     i_b,
    output logic [2*PP_W-1:0]   o_p
);

    logic [2*PP_W-1:0] r_pipe [MULT_LATENCY];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(MULT_LATENCY); i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= (2*PP_W)'(i_a) * (2*PP_W)'(i_b);
            for (int i = 1; i < int'(MULT_LATENCY); i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_p = r_pipe[MULT_LATENCY-1];

endmodule

// File: rtl/cpu_mulx_seq.sv
// Multi-cycle MUL/MULXUU/MULXSU/MULXSS sequencer built from four 16x16 partial products.
// Optional CPU_MULX_EARLY_EXIT_EN: MUL skips the a_hi*b_hi issue and finishes one clock early.
module cpu_mulx_seq
    import cpu_mulx_pkg::*;
#(
    parameter int unsigned MULT_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        cancel,
    input  logic [1:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    mulx_state_e             r_state;
    mulx_op_e                r_op;
    logic [1:0]              r_cnt;
    logic [31:0]             r_src1;
    logic [31:0]             r_src2;
    logic                    r_busy;
    logic                    r_done;
    logic [31:0]             r_result;
    logic [ACC_W-1:0]        r_acc;
    logic [MULT_LATENCY-1:0] r_vld;
    pp_wgt_e                 r_wgt [MULT_LATENCY];

    logic [PP_W-1:0]         w_a;
    logic [PP_W-1:0]         w_b;
    pp_wgt_e                 w_wgt;
    logic [2*PP_W-1:0]       w_pp;
    logic                    w_issue;
    logic                    w_accept;
    logic                    w_last_issue;
    logic                    w_drain_ok;
    logic [31:0]             w_hi;

    assign w_issue  = (r_state == StIssue);
    assign w_accept = start && !cancel && (r_state == StIdle);

`ifdef CPU_MULX_EARLY_EXIT_EN
    // Low word never sees a_hi*b_hi, so MUL can stop after the cross terms.
    assign w_last_issue = (r_cnt == 2'd3) || ((r_cnt == 2'd2) && (r_op == OpMul));
`else
    assign w_last_issue = (r_cnt == 2'd3);
`endif

    always_comb begin
        w_a   = r_src1[PP_W-1:0];
        w_b   = r_src2[PP_W-1:0];
        w_wgt = Wgt0;
        case (r_cnt)
            2'd1: begin
                w_b   = r_src2[2*PP_W-1:PP_W];
                w_wgt = Wgt16;
            end
            2'd2: begin
                w_a   = r_src1[2*PP_W-1:PP_W];
                w_wgt = Wgt16;
            end
            2'd3: begin
                w_a   = r_src1[2*PP_W-1:PP_W];
                w_b   = r_src2[2*PP_W-1:PP_W];
                w_wgt = Wgt32;
            end
            default: ;
        endcase
    end

    cpu_mulx_pp16 #(
        .MULT_LATENCY (MULT_LATENCY)
    ) u_pp16 (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_a     (w_a),
        .i_b     (w_b),
        .o_p     (w_pp)
    );

    // Tags ride alongside the multiplier pipeline so each product finds its weight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld <= '0;
            for (int i = 0; i < int'(MULT_LATENCY); i++) begin
                r_wgt[i] <= Wgt0;
            end
        end else if (cancel) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= w_issue;
            r_wgt[0] <= w_wgt;
            for (int i = 1; i < int'(MULT_LATENCY); i++) begin
                r_vld[i] <= r_vld[i-1];
                r_wgt[i] <= r_wgt[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= '0;
        end else if (w_accept) begin
            r_acc <= '0;
        end else if (r_vld[MULT_LATENCY-1]) begin
            r_acc <= r_acc + pp_align(w_pp, r_wgt[MULT_LATENCY-1]);
        end
    end

    // Leave DRAIN on the edge where the final tag retires into the accumulator.
    always_comb begin
        w_drain_ok = 1'b1;
        for (int i = 0; i < int'(MULT_LATENCY) - 1; i++) begin
            if (r_vld[i]) begin
                w_drain_ok = 1'b0;
            end
        end
    end

    always_comb begin
        w_hi = r_acc[ACC_W-1:32];
        if (((r_op == OpMulxSu) || (r_op == OpMulxSs)) && r_src1[31]) begin
            w_hi = w_hi - r_src2;
        end
        if ((r_op == OpMulxSs) && r_src2[31]) begin
            w_hi = w_hi - r_src1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= StIdle;
            r_op     <= OpMul;
            r_cnt    <= 2'd0;
            r_src1   <= '0;
            r_src2   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else if (cancel) begin
            r_state <= StIdle;
            r_cnt   <= 2'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_op    <= mulx_op_e'(op);
                        r_src1  <= src1;
                        r_src2  <= src2;
                        r_cnt   <= 2'd0;
                        r_busy  <= 1'b1;
                        r_state <= StIssue;
                    end
                end
                StIssue: begin
                    if (w_last_issue) begin
                        r_state <= StDrain;
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                StDrain: begin
                    if (w_drain_ok) begin
                        r_state <= StFix;
                    end
                end
                StFix: begin
                    r_result <= (r_op == OpMul) ? r_acc[31:0] : w_hi;
                    r_done   <= 1'b1;
                    r_state  <= StDone;
                end
                StDone: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_cpu_mulx_seq.sv
// Directed bench for cpu_mulx_seq: products, latency, back-to-back, cancel and mid-op reset.
module tb_cpu_mulx_seq;

`ifdef CPU_MULX_EARLY_EXIT_EN
    localparam int MulLat = 5;
`else
    localparam int MulLat = 6;
`endif
    localparam int MulxLat = 6;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        cancel;
    logic [1:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks;
    int n_errors;

    cpu_mulx_seq #(
        .MULT_LATENCY (1)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .cancel  (cancel),
        .op      (op),
        .src1    (src1),
        .src2    (src2),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Accept one op, wait for done (bounded), check latency, busy and the result.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
        int lat;
        int busy_low;
        @(negedge clk);
        op    = o;
        src1  = a;
        src2  = b;
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        src1     = ~a;
        src2     = ~b;
        lat      = 0;
        busy_low = 0;
        while (!done && lat < 50) begin
            if (!busy) busy_low++;
            @(negedge clk);
            lat++;
        end
        if (!busy) busy_low++;
        check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_res"}, result, exp_res);
        check_eq({tag, "_busy_low"}, 32'(busy_low), 32'd0);
        @(negedge clk);
        check_eq({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        int n_done;
        int t1;
        int t2;
        logic [31:0] r1;
        logic [31:0] r2;
        logic seen_idle;
        int lat;

        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b0;
        start    = 1'b0;
        cancel   = 1'b0;
        op       = 2'd0;
        src1     = '0;
        src2     = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_result", result, 32'd0);
        reset_n = 1'b1;

        run_op("mul_basic", 2'd0, 32'h0001_0003, 32'h0002_0005, MulLat, 32'h000B_000F);
        run_op("mulxuu_ff", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MulxLat, 32'hFFFF_FFFE);
        run_op("mulxss_ff", 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MulxLat, 32'h0000_0000);
        run_op("mulxsu_ff", 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MulxLat, 32'hFFFF_FFFF);
        run_op("mulxss_min", 2'd3, 32'h8000_0000, 32'h8000_0000, MulxLat, 32'h4000_0000);
        run_op("mulxss_neg1", 2'd3, 32'h8000_0000, 32'h0000_0001, MulxLat, 32'hFFFF_FFFF);

        // Back-to-back with start held high; second operand set presented while busy.
        @(negedge clk);
        op    = 2'd1;
        src1  = 32'h1000_0000;
        src2  = 32'h0000_0010;
        start = 1'b1;
        @(negedge clk);
        src1      = 32'h8000_0000;
        src2      = 32'h0000_0008;
        n_done    = 0;
        t1        = 0;
        t2        = 0;
        r1        = '0;
        r2        = '0;
        seen_idle = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                if (n_done == 1) begin
                    t1 = c;
                    r1 = result;
                end else begin
                    t2 = c;
                    r2 = result;
                end
            end
            if (!busy) seen_idle = 1'b1;
            if (seen_idle && busy && start) start = 1'b0;
        end
        start = 1'b0;
        check_eq("b2b_ndone", 32'(n_done), 32'd2);
        check_eq("b2b_t1", 32'(t1), 32'd6);
        check_eq("b2b_t2", 32'(t2), 32'd14);
        check_eq("b2b_r1", r1, 32'h0000_0001);
        check_eq("b2b_r2", r2, 32'h0000_0004);

        // Cancel sampled on the third edge after accept.
        @(negedge clk);
        op    = 2'd1;
        src1  = 32'h1234_5678;
        src2  = 32'h9ABC_DEF0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check_eq("cancel_busy", {31'd0, busy}, 32'd0);
        check_eq("cancel_done", {31'd0, done}, 32'd0);
        check_eq("cancel_result", result, 32'h0000_0004);
        n_done = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check_eq("cancel_no_done", 32'(n_done), 32'd0);
        run_op("mul_7x6", 2'd0, 32'd7, 32'd6, MulLat, 32'h0000_002A);

        // Reset while the op sits in FIX (cycle after edge E5).
        @(negedge clk);
        op    = 2'd1;
        src1  = 32'hFFFF_FFFF;
        src2  = 32'hFFFF_FFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        while (lat < 5) begin
            @(negedge clk);
            lat++;
        end
        check_eq("prefix_busy", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("arst_busy", {31'd0, busy}, 32'd0);
        check_eq("arst_done", {31'd0, done}, 32'd0);
        check_eq("arst_result", result, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        n_done  = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check_eq("arst_no_done", 32'(n_done), 32'd0);
        run_op("mulxss_post", 2'd3, 32'hFFFF_FFFE, 32'h0000_0003, MulxLat, 32'hFFFF_FFFF);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cpu_mulx_seq.md
Name: cpu_mulx_seq

Overview:
- Multi-cycle multiply sequencer in the CPU M-stage. Sits alongside the low-word multiply cell and extends it to the MUL/MULXUU/MULXSU/MULXSS ops.
- Splits each 32x32 operand pair into four 16x16 unsigned partial products and issues them, one per cycle, to a registered 16x16 multiplier.
- Accumulates the 64-bit product, applies signed correction to the high word, and returns a 32-bit result with a done pulse.

Parameters:
- MULT_LATENCY, 1, register stages inside the partial multiplier (legal values 1..2); total latency scales with it.
- PP_W, 16, partial-product operand width; fixed at 16, exposed for the package only.

Ports:
- clk      in   1   CPU clock
- reset_n  in   1   asynchronous active-low reset
- start    in   1   request; accepted only when busy=0
- cancel   in   1   pipeline flush; aborts any operation in flight
- op       in   2   0=MUL (low 32), 1=MULXUU, 2=MULXSU (src1 signed, src2 unsigned), 3=MULXSS; all MULX ops return the high 32 bits
- src1     in   32  multiplicand
- src2     in   32  multiplier
- busy     out  1   operation in flight
- done     out  1   one-cycle pulse; result valid
- result   out  32  product word, held until the next accepted start

Behaviour:
- Reset: the block is in state IDLE; busy=0, done=0, result=0, accumulator=0, partial-multiplier registers=0.
- Accept: at a clock edge with start=1, busy=0 and cancel=0, the block latches op, src1 and src2, moves to ISSUE with cnt=0, and busy goes to 1.
  - start while busy=1 is ignored; no queuing.
- ISSUE, 4 cycles, cnt=0..3: present pp pairs in this fixed order:
  - cnt 0: a_lo*b_lo, weight 0
  - cnt 1: a_lo*b_hi, weight 16
  - cnt 2: a_hi*b_lo, weight 16
  - cnt 3: a_hi*b_hi, weight 32
- Each product is tagged with its weight; the tag travels in a MULT_LATENCY-deep valid/weight shift register.
- Accumulate: a 64-bit unsigned accumulator adds (product << weight) when the tagged valid emerges. Carries propagate across all 64 bits.
- DRAIN: wait until the last tag has retired.
- FIX: hi = acc[63:32].
  - Subtract src2 when op is MULXSU or MULXSS and src1[31]=1.
  - Subtract src1 when op is MULXSS and src2[31]=1.
  - Arithmetic is modulo 2^32.
  - result <= (op==MUL) ? acc[31:0] : hi.
- DONE: done=1 for exactly one cycle; busy stays 1 during this cycle. Next state is IDLE with busy=0.
  - A start may be accepted on the cycle after DONE.
- Latency with MULT_LATENCY=1: accept edge E0 -> done high in the cycle after edge E6 (6 clocks). In general: 5 + MULT_LATENCY clocks.
- cancel=1 at any edge:
  - State goes to IDLE, busy goes to 0, all valid tags are cleared, and no done is produced.
  - result keeps its old value.
  - cancel and start in the same cycle: cancel wins and start is dropped.
- Asynchronous reset mid-operation: immediate return to the reset values; no done pulse.
- Operands are sampled only at accept. Changes on src1/src2/op while busy have no effect.

Optional Feature:
- Macro CPU_MULX_EARLY_EXIT_EN.
- Defined: for op=MUL, the a_hi*b_hi issue (cnt 3) and the FIX subtraction are skipped. done arrives 1 clock earlier (4 + MULT_LATENCY), and the result is identical. MULX ops are unchanged.
- Undefined: all ops use the uniform 5 + MULT_LATENCY latency.

Decomposition:
- Package cpu_mulx_pkg:
  - op encoding enum (MUL, MULXUU, MULXSU, MULXSS)
  - state enum (IDLE, ISSUE, DRAIN, FIX, DONE)
  - PP_W and ACC_W=64 constants
- Sub-module cpu_mulx_pp16: 16x16 unsigned multiplier.
  - Output is MULT_LATENCY-registered.
  - Asynchronous clear on ~reset_n; enable tied high.
  - Maps to a dedicated DSP multiplier.

Test Plan:
- MUL, src1=0x00010003, src2=0x00020005 -> result=0x000B000F, done pulse exactly 6 clocks after accept (5 with CPU_MULX_EARLY_EXIT_EN); busy=1 throughout, then 0.
- MULXUU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULXSS same operands -> 0x00000000; MULXSU same operands -> 0xFFFFFFFF.
- MULXSS 0x80000000 x 0x80000000 -> 0x40000000; MULXSS 0x80000000 x 0x00000001 -> 0xFFFFFFFF.
- Back-to-back: start held high continuously with two operand sets -> second op accepted the cycle after the first done; start pulses while busy are ignored; exactly two done pulses.
- cancel asserted 3 clocks after accepting MULXUU 0x12345678 x 0x9ABCDEF0 -> no done, busy=0 next cycle, result retains previous value; a fresh MUL 7x6 then returns 0x0000002A.
- reset_n asserted low during FIX -> busy, done and result are 0 asynchronously; after release, a MULXSS 0xFFFFFFFE x 0x00000003 returns 0xFFFFFFFF.
